// File: rtl/memory_writeback_stage.sv
// Memory stage + MEM/WB register: non-memory ops write back in 1 cycle, loads/stores take >=2 cycles
// through a req/ready handshake; stall holds upstream while an access waits, and a timeout sets sticky mem_err.
module memory_writeback_stage #(
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [15:0]       ALU,
  input  logic              Z,
  input  logic [15:0]       B,
  input  logic [1:0]        vsel,
  input  logic [1:0]        mem_cmd,
  input  logic [2:0]        write_num,
  input  logic              write,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  output logic              wb_valid,
  output logic [15:0]       wb_data,
  output logic [2:0]        wb_num,
  output logic              wb_write,
  output logic              mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [15:0] pend_val;
  logic [1:0]  pend_vsel;
  logic [2:0]  pend_num;
  logic        pend_write;

  logic        mem_op;
  logic        timeout;
  logic [15:0] sel_val;

  // Load data is not known yet in IDLE, so vsel=01 selects zero here.
  always_comb begin
    sel_val = 16'h0000;
    case (vsel)
      2'b00:   sel_val = ALU;
      2'b10:   sel_val = B;
      2'b11:   sel_val = {15'b0, Z};
      default: sel_val = 16'h0000;
    endcase
  end

  assign mem_op  = in_valid && (mem_cmd == 2'b01 || mem_cmd == 2'b10);
  assign timeout = (state == ACCESS) && !mem_ready && (wait_cnt == 8'(MAX_WAIT - 1));
  // Gated by reset so stall reads 0 while reset is held, whatever the inputs are.
  assign stall   = reset && ((state == IDLE) ? mem_op : (!mem_ready && !timeout));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      pend_val   <= 16'h0000;
      pend_vsel  <= 2'b00;
      pend_num   <= 3'd0;
      pend_write <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 16'h0000;
      wb_valid   <= 1'b0;
      wb_data    <= 16'h0000;
      wb_num     <= 3'd0;
      wb_write   <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state      <= ACCESS;
            wait_cnt   <= 8'd0;
            mem_req    <= 1'b1;
            mem_we     <= (mem_cmd == 2'b10);
            mem_addr   <= ALU[ADDR_W-1:0];
            mem_wdata  <= B;
            pend_val   <= sel_val;
            pend_vsel  <= vsel;
            pend_num   <= write_num;
            pend_write <= write;
            wb_valid   <= 1'b0;
            wb_data    <= 16'h0000;
            wb_num     <= 3'd0;
            wb_write   <= 1'b0;
          end else begin
            wb_valid <= in_valid;
            wb_data  <= sel_val;
            wb_num   <= write_num;
            wb_write <= write && in_valid;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_data  <= (pend_vsel == 2'b01) ? mem_rdata : pend_val;
            wb_num   <= pend_num;
            wb_write <= pend_write;
          end else if (timeout) begin
            // Retire the instruction as a no-write so the pipeline keeps moving.
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_data  <= pend_val;
            wb_num   <= pend_num;
            wb_write <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            wb_valid <= 1'b0;
            wb_data  <= 16'h0000;
            wb_num   <= 3'd0;
            wb_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Directed bench for memory_writeback_stage: inputs driven on negedge, outputs checked before the next posedge.
module tb_memory_writeback_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] ALU;
  logic        Z;
  logic [15:0] B;
  logic [1:0]  vsel;
  logic [1:0]  mem_cmd;
  logic [2:0]  write_num;
  logic        write;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_num;
  logic        wb_write;
  logic        mem_err;

  int tests;
  int failed;

  memory_writeback_stage #(.ADDR_W(9), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALU(ALU), .Z(Z), .B(B),
    .vsel(vsel), .mem_cmd(mem_cmd), .write_num(write_num), .write(write),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_num(wb_num), .wb_write(wb_write),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [15:0] a, input logic z, input logic [15:0] b,
                       input logic [1:0] vs, input logic [1:0] cmd, input logic [2:0] num, input logic w);
    in_valid = v; ALU = a; Z = z; B = b; vsel = vs; mem_cmd = cmd; write_num = num; write = w;
  endtask

  task automatic bubble();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 2'b00, 3'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
    drive(1'b1, 16'h0005, 1'b0, 16'h0000, 2'b01, 2'b01, 3'd1, 1'b1);
    #3;
    tests++;
    if ({stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_num, wb_write, mem_err} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b addr=%h wdata=%h wbv=%b wbd=%h wbn=%0d wbw=%b err=%b, all 0 required",
               stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_num, wb_write, mem_err);
    end
    @(negedge clk);
    bubble();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    logic [15:0] t_alu [5];
    logic        t_z   [5];
    logic [15:0] t_b   [5];
    logic [1:0]  t_vs  [5];
    logic [2:0]  t_num [5];
    logic        t_v   [5];
    logic [15:0] e_dat [5];
    t_alu = '{16'h1234, 16'h5555, 16'h0F0F, 16'h0000, 16'h9999};
    t_z   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t_b   = '{16'h0000, 16'h1111, 16'hA5A5, 16'h2222, 16'h3333};
    t_vs  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    t_num = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    t_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e_dat = '{16'h1234, 16'h0000, 16'hA5A5, 16'h0001, 16'h9999};
    for (int k = 0; k < 5; k++) begin
      drive(t_v[k], t_alu[k], t_z[k], t_b[k], t_vs[k], 2'b00, t_num[k], 1'b1);
      #1;
      tests++;
      if (stall !== 1'b0) begin
        failed++; $display("FAIL alu_stall[%0d]: got %b, want 0", k, stall);
      end
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (wb_valid !== t_v[k] || wb_write !== t_v[k] || (t_v[k] && (wb_data !== e_dat[k] || wb_num !== t_num[k]))) begin
        failed++;
        $display("FAIL alu_wb[%0d]: got v=%b w=%b d=%h n=%0d, want v=%b w=%b d=%h n=%0d",
                 k, wb_valid, wb_write, wb_data, wb_num, t_v[k], t_v[k], e_dat[k], t_num[k]);
      end
    end
    bubble();
  endtask

  task automatic test_load();
    int req_cycles;
    req_cycles = 0;
    drive(1'b1, 16'h0005, 1'b0, 16'h0000, 2'b01, 2'b01, 3'd2, 1'b1);
    #1;
    tests++;
    if (stall !== 1'b1) begin
      failed++; $display("FAIL load_idle_stall: got %b, want 1", stall);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      if (!mem_req) break;
      req_cycles++;
      tests++;
      if (mem_addr !== 9'h005 || mem_we !== 1'b0) begin
        failed++; $display("FAIL load_req[%0d]: addr=%h we=%b, want 005/0", req_cycles, mem_addr, mem_we);
      end
      if (req_cycles == 3) begin
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
      end
      #1;
      tests++;
      if (stall !== (req_cycles < 3)) begin
        failed++; $display("FAIL load_stall[%0d]: got %b, want %b", req_cycles, stall, req_cycles < 3);
      end
    end
    bubble();
    tests++;
    if (req_cycles != 3) begin
      failed++; $display("FAIL load_req_cycles: got %0d, want 3", req_cycles);
    end
    tests++;
    if (wb_valid !== 1'b1 || wb_data !== 16'hBEEF || wb_write !== 1'b1 || wb_num !== 3'd2) begin
      failed++; $display("FAIL load_wb: v=%b d=%h w=%b n=%0d, want 1/BEEF/1/2", wb_valid, wb_data, wb_write, wb_num);
    end
  endtask

  task automatic test_store();
    int req_cycles;
    int stall_cycles;
    req_cycles = 0; stall_cycles = 0;
    drive(1'b1, 16'h0010, 1'b0, 16'hCAFE, 2'b00, 2'b10, 3'd1, 1'b0);
    #1;
    if (stall) stall_cycles++;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      if (!mem_req) break;
      req_cycles++;
      tests++;
      if (mem_we !== 1'b1 || mem_wdata !== 16'hCAFE || mem_addr !== 9'h010) begin
        failed++; $display("FAIL store_req: we=%b wdata=%h addr=%h, want 1/CAFE/010", mem_we, mem_wdata, mem_addr);
      end
      mem_ready = 1'b1;
      #1;
      if (stall) stall_cycles++;
    end
    bubble();
    tests++;
    if (req_cycles != 1 || stall_cycles != 1) begin
      failed++; $display("FAIL store_cycles: req=%0d stall=%0d, want 1/1", req_cycles, stall_cycles);
    end
    tests++;
    if (wb_valid !== 1'b1 || wb_write !== 1'b0) begin
      failed++; $display("FAIL store_wb: v=%b w=%b, want 1/0", wb_valid, wb_write);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    mem_ready = 1'b0;
    drive(1'b1, 16'h0033, 1'b0, 16'h0000, 2'b01, 2'b01, 3'd4, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!mem_req) break;
      req_cycles++;
      #1;
      tests++;
      if (stall !== (req_cycles < 15)) begin
        failed++; $display("FAIL timeout_stall[%0d]: got %b, want %b", req_cycles, stall, req_cycles < 15);
      end
    end
    bubble();
    tests++;
    if (req_cycles != 15) begin
      failed++; $display("FAIL timeout_req_cycles: got %0d, want 15", req_cycles);
    end
    tests++;
    if (mem_err !== 1'b1 || wb_valid !== 1'b1 || wb_write !== 1'b0) begin
      failed++; $display("FAIL timeout_abort: err=%b v=%b w=%b, want 1/1/0", mem_err, wb_valid, wb_write);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (mem_err !== 1'b1 || mem_req !== 1'b0) begin
      failed++; $display("FAIL timeout_sticky: err=%b req=%b, want 1/0", mem_err, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] i_alu [3];
    logic [15:0] i_b   [3];
    logic [1:0]  i_vs  [3];
    logic [1:0]  i_cmd [3];
    logic [2:0]  i_num [3];
    logic        i_w   [3];
    logic [15:0] e_dat [3];
    logic [15:0] g_dat [8];
    logic [2:0]  g_num [8];
    logic        g_w   [8];
    int idx, n_wb, acc;
    i_alu = '{16'h0021, 16'h0022, 16'h7777};
    i_b   = '{16'h0000, 16'h5555, 16'h0000};
    i_vs  = '{2'b01, 2'b10, 2'b00};
    i_cmd = '{2'b01, 2'b10, 2'b00};
    i_num = '{3'd1, 3'd2, 3'd3};
    i_w   = '{1'b1, 1'b0, 1'b1};
    e_dat = '{16'h1111, 16'h5555, 16'h7777};
    idx = 0; n_wb = 0; acc = 0;
    for (int c = 0; c < 40; c++) begin
      if (wb_valid && n_wb < 8) begin
        g_dat[n_wb] = wb_data; g_num[n_wb] = wb_num; g_w[n_wb] = wb_write;
        n_wb++;
      end
      if (mem_req) begin
        acc++;
        mem_ready = (acc >= (mem_we ? 1 : 2));
        mem_rdata = 16'h1111;
      end else begin
        acc = 0; mem_ready = 1'b0;
      end
      if (idx < 3) drive(1'b1, i_alu[idx], 1'b0, i_b[idx], i_vs[idx], i_cmd[idx], i_num[idx], i_w[idx]);
      else bubble();
      #1;
      if (!stall && idx < 3) idx++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    bubble();
    tests++;
    if (n_wb != 3) begin
      failed++; $display("FAIL b2b_count: got %0d writebacks, want 3", n_wb);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (k >= n_wb || g_dat[k] !== e_dat[k] || g_num[k] !== i_num[k] || g_w[k] !== i_w[k]) begin
        failed++;
        $display("FAIL b2b_wb[%0d]: got d=%h n=%0d w=%b, want d=%h n=%0d w=%b",
                 k, g_dat[k], g_num[k], g_w[k], e_dat[k], i_num[k], i_w[k]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 16'h0044, 1'b0, 16'h0000, 2'b01, 2'b01, 3'd6, 1'b1);
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1) begin
      failed++; $display("FAIL rst_mid_pre: req=%b, want 1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_num, wb_write, mem_err} !== '0) begin
      failed++;
      $display("FAIL rst_mid_outputs: stall=%b req=%b addr=%h wbv=%b err=%b, all 0 required",
               stall, mem_req, mem_addr, wb_valid, mem_err);
    end
    @(negedge clk);
    bubble();
    reset = 1'b1;
    @(negedge clk);
    drive(1'b1, 16'h0077, 1'b0, 16'h0000, 2'b01, 2'b01, 3'd5, 1'b1);
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'h1357;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 9'h077) begin
      failed++; $display("FAIL rst_mid_after_req: req=%b addr=%h, want 1/077", mem_req, mem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    bubble();
    tests++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h1357 || wb_num !== 3'd5 || wb_write !== 1'b1 || mem_req !== 1'b0) begin
      failed++; $display("FAIL rst_mid_after_wb: v=%b d=%h n=%0d w=%b req=%b, want 1/1357/5/1/0",
                         wb_valid, wb_data, wb_num, wb_write, mem_req);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_alu_ops();
    test_load();
    test_store();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
